// File: rtl/multdiv_engine.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Start pulse captures operands; result lands 32 edges later with a one-cycle ready pulse.
module multdiv_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  // Shared work register: multiply {hi, lo, q-1}; divide {rem(W+1), quo(W)}.
  logic [2*WIDTH:0]     prod;
  logic [WIDTH:0]       opnd;
  logic                 q_neg, div_zero, div_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  logic             last;
  logic [WIDTH:0]   hi_ext, booth_sum;
  logic [2*WIDTH:0] mul_nxt;
  logic [WIDTH:0]   hi_chk;
  logic             mul_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [2*WIDTH:0] div_nxt;
  logic [WIDTH-1:0] quo, quo_s;

  assign last = (cnt == CNT_W'(WIDTH-1));

  // Booth step: add in WIDTH+1 bits so that subtracting -2^(W-1) cannot wrap.
  always_comb begin
    hi_ext = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    booth_sum = hi_ext;
    case (prod[1:0])
      2'b01:   booth_sum = hi_ext + opnd;
      2'b10:   booth_sum = hi_ext - opnd;
      default: booth_sum = hi_ext;
    endcase
  end

  assign mul_nxt = {booth_sum, prod[WIDTH:1]};
  assign hi_chk  = mul_nxt[2*WIDTH:WIDTH];
  assign mul_ovf = !((&hi_chk) || (~|hi_chk));

  // Restoring divide step on magnitudes.
  assign shifted = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {1'b0, opnd};
  assign div_nxt = trial[WIDTH+1] ? {shifted, prod[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH:0], prod[WIDTH-2:0], 1'b1};
  assign quo     = div_nxt[WIDTH-1:0];
  assign quo_s   = q_neg ? ('0 - quo) : quo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      prod           <= '0;
      opnd           <= '0;
      q_neg          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MUL_RUN;
        cnt   <= '0;
        prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        opnd  <= {data_operandA[WIDTH-1], data_operandA};
      end else if (ctrl_DIV) begin
        state    <= DIV_RUN;
        cnt      <= '0;
        prod     <= {{(WIDTH+1){1'b0}}, mag(data_operandA)};
        opnd     <= {1'b0, mag(data_operandB)};
        q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= ~|data_operandB;
        div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
      end else begin
        case (state)
          MUL_RUN: begin
            prod <= mul_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
              data_result    <= mul_nxt[WIDTH:1];
              data_exception <= mul_ovf;
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end
          end
          DIV_RUN: begin
            prod <= div_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
              data_result    <= div_zero ? '0 : quo_s;
              data_exception <= div_zero | div_ovf;
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_engine.sv
// Directed bench for multdiv_engine: latency, results, exceptions, abort and mid-run reset.
module tb_multdiv_engine;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] opa = '0, opb = '0;
  logic        mult = 1'b0, div = 1'b0;
  logic [31:0] result;
  logic        exc, rdy;
  int          checks = 0, errors = 0;

  multdiv_engine #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(opa), .data_operandB(opb),
    .ctrl_MULT(mult), .ctrl_DIV(div),
    .data_result(result), .data_exception(exc), .data_resultRDY(rdy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Start pulse is high across exactly one rising edge (E0).
  task automatic start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock); opa = a; opb = b; mult = m; div = d;
    @(negedge clock); mult = 1'b0; div = 1'b0;
  endtask

  // Returns number of edges after E0 until rdy; 0 if it never came.
  task automatic wait_rdy(input bit scramble, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (scramble) begin opa = $urandom; opb = $urandom; end
      if (rdy) begin n = i; break; end
    end
  endtask

  task automatic run_op(input string tag, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e, input bit scramble);
    int n;
    start(m, d, a, b);
    wait_rdy(scramble, n);
    chk({tag, "_lat"}, n, 32);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_exc"}, {31'b0, exc}, {31'b0, exp_e});
    @(posedge clock); #1;
    chk({tag, "_rdy_drop"}, {31'b0, rdy}, 32'd0);
    chk({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int n, seen;
    repeat (3) @(negedge clock);
    chk("rst_res", result, 32'd0);
    chk("rst_exc", {31'b0, exc}, 32'd0);
    chk("rst_rdy", {31'b0, rdy}, 32'd0);
    reset = 1'b0;

    run_op("mul_7x-3",    1, 0, 32'd7,          -32'sd3,        32'hFFFFFFEB, 1'b0, 0);
    run_op("mul_2^32",    1, 0, 32'h00010000,   32'h00010000,   32'h00000000, 1'b1, 0);
    // -46341*46341 = -2147488281 = 0xFFFFFFFF_7FFFEDE7
    run_op("mul_46341",   1, 0, -32'sd46341,    32'd46341,      32'h7FFFEDE7, 1'b1, 0);
    run_op("mul_min_x-1", 1, 0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1, 0);
    run_op("div_-100/7",  0, 1, -32'sd100,      32'd7,          32'hFFFFFFF2, 1'b0, 0);
    run_op("div_100/-7",  0, 1, 32'd100,        -32'sd7,        32'hFFFFFFF2, 1'b0, 0);
    run_op("div_5/0",     0, 1, 32'd5,          32'd0,          32'h00000000, 1'b1, 0);
    run_op("div_min/-1",  0, 1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1, 1);
    run_op("div_min/1",   0, 1, 32'h80000000,   32'd1,          32'h80000000, 1'b0, 0);

    // Abort: multiply restarted by a divide at iteration 15.
    start(1, 0, 32'd7, 32'd3);
    seen = 0;
    repeat (14) begin @(posedge clock); #1; if (rdy) seen++; end
    start(0, 1, 32'd10, 32'd2);
    wait_rdy(0, n);
    chk("abort_no_mul_rdy", seen, 0);
    chk("abort_lat", n, 32);
    chk("abort_res", result, 32'd5);

    run_op("both_6x2", 1, 1, 32'd6, 32'd2, 32'd12, 1'b0, 0);

    // Asynchronous reset between edges during a divide.
    start(0, 1, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_res", result, 32'd0);
    chk("arst_exc", {31'b0, exc}, 32'd0);
    chk("arst_rdy", {31'b0, rdy}, 32'd0);
    @(negedge clock); reset = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clock); #1; if (rdy) seen++; end
    chk("arst_no_rdy", seen, 0);
    chk("arst_res_kept", result, 32'd0);

    run_op("mul_2x2", 1, 0, 32'd2, 32'd2, 32'd4, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
